// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline-control types for the stall/flush controller.
// Holds the controller state encoding, the enable bundle and the watchdog default.
package stall_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } stall_state_t;

  // Pipeline register enables, IF side first.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } pipe_en_t;

  localparam int unsigned LOCK_MAX_DEFAULT = 4;

endpackage

// File: rtl/stall_ctrl_lock_watchdog.sv
// Lock watchdog: saturating count of consecutive interlock cycles plus a sticky trip flag.
// Frozen cycles (memory busy or halted) neither advance nor clear the run length.
module lock_watchdog #(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_active,
  input  logic freeze,
  output logic lock_err
);

  localparam logic [3:0] LOCK_MAX_4 = 4'(LOCK_MAX);

  logic [3:0] r_lock_run;
  logic [3:0] w_lock_run_next;
  logic       r_lock_err;

  always_comb begin
    w_lock_run_next = r_lock_run;
    if (!freeze) begin
      if (lock_active)
        w_lock_run_next = (r_lock_run == 4'hF) ? 4'hF : r_lock_run + 4'd1;
      else
        w_lock_run_next = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_run <= 4'd0;
      r_lock_err <= 1'b0;
    end else begin
      r_lock_run <= w_lock_run_next;
      // Sticky until reset; the stall decode itself never looks at this flag.
      r_lock_err <= r_lock_err | (w_lock_run_next >= LOCK_MAX_4);
    end
  end

  assign lock_err = r_lock_err;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: RUN/HALT state plus zero-latency enable decode.
// Optional performance counters are built when STALL_CTRL_PERF_EN is defined.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic nop_lock_id,
  input  logic branch_taken_id,
  input  logic mem_busy,
  input  logic halt_wb,
  input  logic go,
  output logic pc_en,
  output logic if_id_en,
  output logic id_ex_en,
  output logic ex_mem_en,
  output logic mem_wb_en,
  output logic if_id_flush,
  output logic id_ex_bubble,
  output logic halted,
  output logic lock_err
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  stall_state_t r_state;
  stall_state_t w_state_next;
  pipe_en_t     w_en;
  logic         w_flush;
  logic         w_bubble;
  logic         w_lock_active;
  logic         w_freeze;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // Decode must stay combinational: nop_lock_id arrives late from ID in the same cycle.
  always_comb begin
    w_state_next  = r_state;
    w_en          = '{default: 1'b1};
    w_flush       = 1'b0;
    w_bubble      = 1'b0;
    w_lock_active = 1'b0;
    if (!rst) begin
      if (r_state == HALT) begin
        w_en = '{default: 1'b0};
        if (go) w_state_next = RUN;
      end else begin
        // WB stays frozen while mem_busy, so a deferred halt_wb is still present later.
        if (halt_wb && !mem_busy) w_state_next = HALT;
        if (mem_busy) begin
          w_en = '{default: 1'b0};
        end else if (nop_lock_id) begin
          w_en.pc       = 1'b0;
          w_en.if_id    = 1'b0;
          w_bubble      = 1'b1;
          w_lock_active = 1'b1;
        end else if (branch_taken_id) begin
          w_flush = 1'b1;
        end
      end
    end
  end

  assign w_freeze = (r_state == HALT) | mem_busy;

  lock_watchdog #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_watchdog (
    .clk         (clk),
    .rst         (rst),
    .lock_active (w_lock_active),
    .freeze      (w_freeze),
    .lock_err    (lock_err)
  );

  assign pc_en        = w_en.pc;
  assign if_id_en     = w_en.if_id;
  assign id_ex_en     = w_en.id_ex;
  assign ex_mem_en    = w_en.ex_mem;
  assign mem_wb_en    = w_en.mem_wb;
  assign if_id_flush  = w_flush;
  assign id_ex_bubble = w_bubble;
  assign halted       = (r_state == HALT);

`ifdef STALL_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (!w_en.pc)  r_stall_cnt  <= r_stall_cnt + 1'b1;
      if (w_bubble)  r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (w_flush)   r_flush_cnt  <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule
